// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier: one Booth step per clock, start/busy/done handshake.
// The accumulator is one bit wider than the operands so that negating the most negative multiplicand stays exact.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH:0]     acc, acc_nx, acc_t;
  logic [WIDTH:0]     mcand, mcand_nx;
  logic [WIDTH-1:0]   mq, mq_nx;
  logic               q_m1, q_m1_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [2*WIDTH-1:0] prod_nx;

  // Next-state and datapath: accept in IDLE, one add/sub + arithmetic shift per RUN cycle
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    mcand_nx = mcand;
    mq_nx    = mq;
    q_m1_nx  = q_m1;
    cnt_nx   = cnt;
    prod_nx  = product;
    acc_t    = acc;
    case (state)
      S_IDLE: begin
        if (start) begin
          mcand_nx = {multiplicand[WIDTH-1], multiplicand};
          acc_nx   = '0;
          mq_nx    = multiplier;
          q_m1_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        case ({mq[0], q_m1})
          2'b01:   acc_t = acc + mcand;
          2'b10:   acc_t = acc - mcand;
          default: acc_t = acc;
        endcase
        acc_nx  = {acc_t[WIDTH], acc_t[WIDTH:1]};
        mq_nx   = {acc_t[0], mq[WIDTH-1:1]};
        q_m1_nx = mq[0];
        cnt_nx  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_nx = S_DONE;
          prod_nx  = {acc_nx[WIDTH-1:0], mq_nx};
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mq      <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      mcand   <= mcand_nx;
      mq      <= mq_nx;
      q_m1    <= q_m1_nx;
      cnt     <= cnt_nx;
      product <= prod_nx;
      busy    <= (state_nx == S_RUN);
      done    <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomized self-checking bench for booth_mult_seq (WIDTH = 16).
module tb_booth_mult_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  booth_mult_seq #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start one operation from IDLE, wait for done, check latency, busy span and result.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input bit noise);
    int  k;
    bit  busy_ok;
    start = 1'b1; multiplicand = a; multiplier = b;
    @(posedge clk); #1;
    check({tag, "_busy_accept"}, 32'(busy), 32'd1);
    start = 1'b0;
    multiplicand = 16'($urandom); multiplier = 16'($urandom);
    k = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && k < 40) begin
      if (noise) begin
        start = ~start; multiplicand = 16'h7FFF; multiplier = 16'h7FFF;
      end
      @(posedge clk); #1;
      k++;
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(k), 32'd16);
    check({tag, "_busy_span"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_product"}, product, exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_product_hold"}, product, exp);
  endtask

  initial begin
    logic [15:0] ra, rb, na, nb;
    logic [31:0] rexp, prev;
    int          k;
    bit          seen, stable;

    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    #1;
    check("reset_outputs", {busy, done, 30'd0}, 32'd0);
    check("reset_product", product, 32'd0);
    #20;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_product_zero", product, 32'd0);

    do_op("t1_3x5", 16'd3, 16'd5, 32'h0000_000F, 1'b0);
    do_op("t2_m7x6", 16'hFFF9, 16'd6, 32'hFFFF_FFD6, 1'b0);
    do_op("t2_6xm7", 16'd6, 16'hFFF9, 32'hFFFF_FFD6, 1'b0);
    do_op("t3_minxmin", 16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
    do_op("t3_maxxmin", 16'h7FFF, 16'h8000, 32'hC000_8000, 1'b0);
    do_op("t3_m1xm1", 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0);
    do_op("t4_1234x0", 16'd1234, 16'd0, 32'h0000_0000, 1'b0);
    do_op("t4_ignored_start", 16'd25, 16'd4, 32'h0000_0064, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("t4_no_extra_done", {30'd0, busy, done}, 32'd0);
    end

    // Reset mid-operation abandons the product in flight
    start = 1'b1; multiplicand = 16'd100; multiplier = 16'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("t5_rst_product", product, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("t5_no_done_after_rst", 32'(seen), 32'd0);
    do_op("t5_100x200", 16'd100, 16'd200, 32'd20000, 1'b0);

    // Start held high: accepts every 18 cycles, product holds between dones
    na = 16'($urandom); nb = 16'($urandom);
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = na; rb = nb;
      if (i == 0) begin ra = 16'h8000; rb = 16'h8000; end
      if (i == 1) begin ra = 16'h8000; rb = 16'h7FFF; end
      multiplicand = ra; multiplier = rb;
      rexp = 32'(longint'($signed(ra)) * longint'($signed(rb)));
      prev = product;
      @(posedge clk); #1;
      check("t6_accept_busy", 32'(busy), 32'd1);
      na = 16'($urandom); nb = 16'($urandom);
      multiplicand = na; multiplier = nb;
      k = 0; stable = 1'b1;
      while (done !== 1'b1 && k < 40) begin
        @(posedge clk); #1;
        k++;
        if (done !== 1'b1 && product !== prev) stable = 1'b0;
      end
      check("t6_latency", 32'(k), 32'd16);
      check("t6_stable", 32'(stable), 32'd1);
      check("t6_product", product, rexp);
      @(posedge clk); #1;
      check("t6_idle_gap", {30'd0, busy, done}, 32'd0);
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
